// File: rtl/ubtb_upd_ctrl_pkg.sv
// Shared types and constants for the micro-BTB update scheduler.
// The PC pre-hash layout defines which PC bits select a uBTB entry.
package ubtb_upd_ctrl_pkg;

  localparam int MXLEN               = 32;
  localparam int uBTB_INDEX_LEN      = 4;
  localparam int uBTB_PC_OFS_LEN     = 2;
  localparam int uBTB_UPDQ_DEPTH     = 4;
  localparam int uBTB_UPD_STARVE_MAX = 3;

  typedef struct packed {
    logic [MXLEN-uBTB_INDEX_LEN-uBTB_PC_OFS_LEN-1:0] pc_tag;
    logic [uBTB_INDEX_LEN-1:0]                       pc_index;
    logic [uBTB_PC_OFS_LEN-1:0]                      pc_ofs;
  } pc_uPrehash_t;

  typedef struct packed {
    logic [MXLEN-1:0] src;
    logic [MXLEN-1:0] dst;
  } ubtb_updReq_t;

  function automatic logic [uBTB_INDEX_LEN-1:0] ubtb_idx(input pc_uPrehash_t pc);
    return pc.pc_index;
  endfunction

endpackage

// File: rtl/ubtb_upd_ctrl_if.sv
// Training-request, uBTB read-probe and uBTB write-port bundle of the update scheduler.
interface ubtb_upd_ctrl_if
  import ubtb_upd_ctrl_pkg::*;
#(
  parameter int QDEPTH = uBTB_UPDQ_DEPTH
);
  logic             i_ex_upd_vld;
  logic [MXLEN-1:0] i_ex_upd_src;
  logic [MXLEN-1:0] i_ex_upd_dst;
  logic             o_ex_upd_rdy;
  logic             i_dc_upd_vld;
  logic [MXLEN-1:0] i_dc_upd_src;
  logic [MXLEN-1:0] i_dc_upd_dst;
  logic             o_dc_upd_rdy;
  logic             i_flush;
  logic             i_nPc_vld;
  logic [MXLEN-1:0] i_nPc;
  logic             o_ubtb_update;
  logic [MXLEN-1:0] o_pc_jumpsrc;
  logic [MXLEN-1:0] o_pc_jumpdst;
  logic [$clog2(QDEPTH):0] o_q_count;
  logic             o_forced_wr;

  modport master (
    output i_ex_upd_vld, i_ex_upd_src, i_ex_upd_dst,
    output i_dc_upd_vld, i_dc_upd_src, i_dc_upd_dst,
    output i_flush, i_nPc_vld, i_nPc,
    input  o_ex_upd_rdy, o_dc_upd_rdy, o_ubtb_update,
    input  o_pc_jumpsrc, o_pc_jumpdst, o_q_count, o_forced_wr
  );

  modport slave (
    input  i_ex_upd_vld, i_ex_upd_src, i_ex_upd_dst,
    input  i_dc_upd_vld, i_dc_upd_src, i_dc_upd_dst,
    input  i_flush, i_nPc_vld, i_nPc,
    output o_ex_upd_rdy, o_dc_upd_rdy, o_ubtb_update,
    output o_pc_jumpsrc, o_pc_jumpdst, o_q_count, o_forced_wr
  );
endinterface

// File: rtl/ubtb_upd_fifo.sv
// Deduplicating update queue: a request whose src is already queued (and not
// leaving this cycle) rewrites that entry's dst instead of taking a new slot.
module ubtb_upd_fifo
  import ubtb_upd_ctrl_pkg::*;
#(
  parameter int QDEPTH = uBTB_UPDQ_DEPTH
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic                      i_flush,
  input  logic                      i_enq,
  input  ubtb_updReq_t              i_req,
  input  logic                      i_pop,
  output ubtb_updReq_t              o_head,
  output logic                      o_empty,
  output logic                      o_full,
  output logic [$clog2(QDEPTH):0]   o_count
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  ubtb_updReq_t      mem [QDEPTH];
  logic [QDEPTH-1:0] vld_q;
  logic [PW:0]       wptr_q, rptr_q;
  logic [CW-1:0]     cnt_q;
  logic [QDEPTH-1:0] hit;
  logic [PW-1:0]     rd_idx, wr_idx;
  logic              merge, push;

  assign rd_idx = rptr_q[PW-1:0];
  assign wr_idx = wptr_q[PW-1:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hit = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      hit[i] = vld_q[i] && (mem[i].src == i_req.src) && !(i_pop && (PW'(i) == rd_idx));
    end
  end

  assign merge = i_enq && (|hit);
  assign push  = i_enq && !merge;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vld_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (i_flush) begin
      vld_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (i_pop) begin
        vld_q[rd_idx] <= 1'b0;
        rptr_q        <= rptr_q + 1'b1;
      end
      if (push) begin
        vld_q[wr_idx] <= 1'b1;
        wptr_q        <= wptr_q + 1'b1;
      end
      cnt_q <= cnt_q + CW'(push) - CW'(i_pop);
    end
  end

  // NOTE: payload storage is not reset; valid bits and count alone decide what is live.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < QDEPTH; i++) begin
      if (push && (PW'(i) == wr_idx)) mem[i] <= i_req;
      else if (merge && hit[i])       mem[i].dst <= i_req.dst;
    end
  end

  assign o_head  = mem[rd_idx];
  assign o_empty = (cnt_q == '0);
  assign o_full  = (cnt_q == CW'(QDEPTH));
  assign o_count = cnt_q;

endmodule

// File: rtl/ubtb_upd_ctrl.sv
// micro-BTB update scheduler: EX/DC arbitration, read-index conflict hold-off
// with a starvation bound, and the uBTB write-port drive.
module ubtb_upd_ctrl
  import ubtb_upd_ctrl_pkg::*;
#(
  parameter int QDEPTH     = uBTB_UPDQ_DEPTH,
  parameter int STARVE_MAX = uBTB_UPD_STARVE_MAX
) (
  input logic            i_clk,
  input logic            i_rstn,
  ubtb_upd_ctrl_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  ubtb_updReq_t  enq_req, head;
  logic          ex_acc, dc_acc, enq, pop, empty, full, conflict, forced;
  logic [SW-1:0] starve_q;

  // EX wins outright; DC only gets a slot in cycles EX is silent.
  assign bus.o_ex_upd_rdy = !full && !bus.i_flush;
  assign bus.o_dc_upd_rdy = !full && !bus.i_flush && !bus.i_ex_upd_vld;
  assign ex_acc  = bus.i_ex_upd_vld && bus.o_ex_upd_rdy;
  assign dc_acc  = bus.i_dc_upd_vld && bus.o_dc_upd_rdy;
  assign enq     = ex_acc || dc_acc;
  assign enq_req = ex_acc ? '{src: bus.i_ex_upd_src, dst: bus.i_ex_upd_dst}
                          : '{src: bus.i_dc_upd_src, dst: bus.i_dc_upd_dst};

  ubtb_upd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_flush (bus.i_flush),
    .i_enq   (enq),
    .i_req   (enq_req),
    .i_pop   (pop),
    .o_head  (head),
    .o_empty (empty),
    .o_full  (full),
    .o_count (bus.o_q_count)
  );

  assign conflict = bus.i_nPc_vld && (ubtb_idx(bus.i_nPc) == ubtb_idx(head.src));
  assign forced   = (starve_q == SW'(STARVE_MAX));
  assign pop      = !empty && !bus.i_flush && (!conflict || forced);

  // Counts cycles the head has been pushed back by the read port.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)                              starve_q <= '0;
    else if (bus.i_flush || empty || pop)     starve_q <= '0;
    else if (conflict && !forced)             starve_q <= starve_q + 1'b1;
  end

  assign bus.o_ubtb_update = pop;
  assign bus.o_forced_wr   = pop && conflict;
  assign bus.o_pc_jumpsrc  = empty ? '0 : head.src;
  assign bus.o_pc_jumpdst  = empty ? '0 : head.dst;

endmodule

// File: doc/ubtb_upd_ctrl.md
Name: ubtb_upd_ctrl

Overview:
Update scheduler for the micro-BTB. It accepts jump-target training requests from two sources: execute-stage resolve (EX) and decode-stage predecode fix (DC). Requests are buffered in a small deduplicating queue and issued one per cycle on the uBTB write port. Writes are held off when they collide with the same-cycle uBTB read index, with a starvation bound, and the whole queue is dropped on pipeline flush.

Parameters:
MXLEN, 32, PC/target width
QDEPTH, 4, update queue entries (power of 2, >=2)
INDEX_LEN, 4, uBTB index width (equals uBTB_INDEX_LEN)
STARVE_MAX, 3, max consecutive deferred cycles before a forced write

Ports:
i_clk  in  1  clock
i_rstn  in  1  async active-low reset
i_ex_upd_vld  in  1  EX update request
i_ex_upd_src  in  MXLEN  EX jump source PC
i_ex_upd_dst  in  MXLEN  EX jump target
o_ex_upd_rdy  out  1  EX request accepted when vld&rdy
i_dc_upd_vld  in  1  DC update request
i_dc_upd_src  in  MXLEN  DC jump source PC
i_dc_upd_dst  in  MXLEN  DC jump target
o_dc_upd_rdy  out  1  DC request accepted when vld&rdy
i_flush  in  1  synchronous queue drop
i_nPc_vld  in  1  uBTB read enable this cycle
i_nPc  in  MXLEN  uBTB read PC this cycle
o_ubtb_update  out  1  uBTB write strobe
o_pc_jumpsrc  out  MXLEN  write source PC
o_pc_jumpdst  out  MXLEN  write target
o_q_count  out  $clog2(QDEPTH)+1  occupied entries
o_forced_wr  out  1  current write overrides a read conflict

Behaviour:
- Reset is i_rstn, asynchronous, active-low; clock is i_clk.
- Reset values:
  - Queue empty, pointers 0, starve counter 0.
  - o_q_count=0, o_ubtb_update=0, o_forced_wr=0.
  - o_pc_jumpsrc/o_pc_jumpdst=0 while the queue is empty.
- Index function idx(pc) = bpu_pkg pc_uPrehash_t.pc_index field of pc.
- Queue pointers carry an extra wrap bit. full = count==QDEPTH; empty = count==0.
- Ready signals:
  - o_ex_upd_rdy = !full && !i_flush.
  - o_dc_upd_rdy = !full && !i_flush && !i_ex_upd_vld. EX has fixed priority; at most one enqueue per cycle.
  - No same-cycle pop bypass: rdy stays low when full, even if a pop occurs that cycle.
- Dedup:
  - If the accepted src equals the src of a valid queued entry other than an entry popping this cycle, that entry's dst is overwritten in place. No new entry is added, so count does not increase.
  - If the accepted src matches the head that is popping this cycle, the request is enqueued as a new entry.
- Issue (combinational from head, 1-cycle latency):
  - A request accepted at the edge ending cycle N appears on o_ubtb_update in cycle N+1 if it is the head.
  - conflict = i_nPc_vld && idx(i_nPc)==idx(head.src).
  - o_ubtb_update = !empty && !i_flush && (!conflict || starve_cnt==STARVE_MAX).
  - o_pc_jumpsrc/o_pc_jumpdst = head fields whenever non-empty.
  - Pop head at the edge when o_ubtb_update=1.
- Starvation:
  - starve_cnt increments (saturating) each cycle the head is deferred by conflict.
  - It clears on any pop, on flush, and whenever the queue is empty.
  - o_forced_wr = o_ubtb_update && conflict.
- Flush:
  - While i_flush=1: rdys=0, o_ubtb_update=0.
  - At the edge: queue emptied, starve_cnt=0. Any enqueue that cycle is discarded.
- Count:
  - o_q_count is registered.
  - It changes by +1 (enqueue-new only), -1 (pop only), or 0 (both, neither, or dedup-merge only).
  - Dedup-merge together with a pop gives -1.
- Reset mid-operation: everything returns to reset values immediately; no write strobe during reset.

Decomposition:
- bpu_pkg additions:
  - ubtb_updReq_t {src[MXLEN], dst[MXLEN]}.
  - Constants uBTB_UPDQ_DEPTH=4 and uBTB_UPD_STARVE_MAX=3.
  - Reuse the existing pc_uPrehash_t for index extraction.
- One sub-module, ubtb_upd_fifo: storage, valid bits, pointers, dedup CAM compare/merge, flush clear.
- Top level holds arbitration, conflict check, starve counter and output muxing.

Test Plan:
1. Reset, then EX req src=0x100 dst=0x400 in cycle 1, i_nPc_vld=0 -> cycle 2: o_ubtb_update=1, src=0x100, dst=0x400; cycle 3: o_q_count=0, strobe 0.
2. EX and DC valid together (EX src=0x200, DC src=0x300) -> o_ex_upd_rdy=1, o_dc_upd_rdy=0. DC is held and accepted next cycle. Writes issue in order 0x200, then 0x300.
3. Fill 4 entries with strobes blocked by conflict -> o_q_count=4, both rdy=0. A 5th request is not accepted until a pop occurs.
4. Queue holds src=0x100 dst=0x400, head blocked; EX src=0x100 dst=0x500 arrives -> o_q_count stays 1; the eventual write carries dst=0x500.
5. Head src=0x104, i_nPc_vld=1 with i_nPc=0x104 held -> strobe deferred 3 cycles; 4th cycle o_ubtb_update=1 and o_forced_wr=1.
6. Queue with 3 entries, assert i_flush together with an EX request -> strobe 0 and rdy 0 that cycle; next cycle o_q_count=0, no write issued. Asserting i_rstn low mid-drain clears all outputs immediately.
